e_mdu_multicycle: RTL and testbench
===================================

// Module: e_mdu_multicycle
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core.
//   Executes mult/multu/div/divu over a fixed, configurable latency and holds the HI/LO registers.
//   Services mfhi/mflo/mthi/mtlo.
//   Drives a stall request so that D_CU-decoded MDU instructions hold in D while the unit is busy.
// PARAMETERS
//   WIDTH        32  operand, HI and LO width
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high; clears all state
//   start      in   1      E-stage MDU instruction valid this cycle
//   mdu_op     in   4      0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo; 9-15 = none
//   src_a      in   WIDTH  rs value (dividend / multiplicand / mthi-mtlo data)
//   src_b      in   WIDTH  rt value (divisor / multiplier)
//   d_is_mdu   in   1      instruction in D uses the MDU (any op 1-8)
//   busy       out  1      operation in flight
//   stall_req  out  1      busy | (start & mdu_op in 1..4); D-stage stall when d_is_mdu
//   hi         out  WIDTH  architectural HI
//   lo         out  WIDTH  architectural LO
//   mdu_out    out  WIDTH  combinational: hi for mfhi, lo for mflo, else 0
// BEHAVIOUR
//   Reset: busy=0, counter=0, hi=0, lo=0, pending result=0. Reset is asynchronous and takes effect mid-operation; the in-flight result is discarded.
//   Counter: width clog2(max(MULT_CYCLES,DIV_CYCLES)+1). busy = (counter != 0).
//   IDLE -> RUN: at an edge with start=1, busy=0 and op 1-4:
//     - compute the 2*WIDTH result into the pending regs;
//     - load counter with MULT_CYCLES or DIV_CYCLES.
//   RUN: the counter decrements each edge. At the edge where it goes 1->0:
//     - hi/lo <= pending;
//     - busy falls. The result is visible the same cycle busy=0.
//   Latency: start sampled at edge t -> busy=1 during cycles t..t+N-1; hi/lo updated at edge t+N.
//   mult:  {hi,lo} = signed(src_a)*signed(src_b). multu: unsigned product, full 2*WIDTH bits.
//   div:   lo = quotient, truncated toward zero; hi = remainder, sign of the dividend.
//   divu:  unsigned quotient and remainder.
//   div by zero (src_b==0): the unit still goes busy for DIV_CYCLES; hi/lo are left unchanged at commit.
//   Signed overflow (MIN / -1): lo = MIN, hi = 0.
//   mthi/mtlo with start=1 and busy=0: hi (or lo) <= src_a at the next edge; busy stays 0.
//   mfhi/mflo: mdu_out is a pure read of the current hi/lo; no state change.
//   Any start with busy=1 is ignored, including mthi/mtlo. The stall logic guarantees this does not occur; verification flags it with an assertion.
//   start with op 0 or 9-15: no effect.
//   No new op is accepted on the commit edge itself (busy is still 1); the earliest next start is the cycle after.
// TESTING
//   1 Reset then idle: hi=lo=0, busy=0, stall_req=0, mdu_out=0 for mfhi.
//   2 mult 0xFFFFFFFE*3 (signed) -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//     The same operands as multu -> hi=0x2, lo=0xFFFFFFFA.
//   3 div -7/2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     div 0x80000000/-1 -> lo=0x80000000, hi=0.
//   4 mthi 0x1234 then divu 5/0 -> hi stays 0x1234 after busy drops; lo unchanged.
//   5 Assert reset at cycle 3 of a mult -> busy=0, hi=lo=0 immediately; no commit follows.
//   6 With busy=1, pulse start with mtlo 0xAAAA -> lo unchanged; stall_req=1 throughout busy.

Source files
------------

// File: rtl/e_mdu_multicycle.sv
// Multi-cycle multiply/divide unit for the E stage: fixed-latency mult/div,
// architectural HI/LO, mfhi/mflo/mthi/mtlo and the D-stage stall request.
module e_mdu_multicycle #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             d_is_mdu,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdu_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N   = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N    = CW'(DIV_CYCLES);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_wr;

  logic             is_mult, is_muldiv;
  logic             launch, commit, mt_hi, mt_lo;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   abs_a, abs_b, div_b, uq, ur;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_wr, sgn_div, b_zero;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_RUN;
      S_RUN:   if (commit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs and strobes ----------------
  always_comb begin
    busy      = (cnt != '0);
    is_mult   = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    is_muldiv = is_mult || (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    launch    = start && !busy && is_muldiv && (state == S_IDLE);
    commit    = (state == S_RUN) && (cnt == CW'(1));
    mt_hi     = start && !busy && (mdu_op == OP_MTHI);
    mt_lo     = start && !busy && (mdu_op == OP_MTLO);
    stall_req = d_is_mdu && (busy || (start && is_muldiv));
    mdu_out   = '0;
    if (mdu_op == OP_MFHI)      mdu_out = hi;
    else if (mdu_op == OP_MFLO) mdu_out = lo;
  end

  // Result is computed at launch and parked in pend_*; the counter only
  // models the architectural latency.
  always_comb begin
    sgn_div = (mdu_op == OP_DIV);
    b_zero  = (src_b == '0);
    prod_s  = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    prod_u  = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    abs_a   = (sgn_div && src_a[WIDTH-1]) ? ('0 - src_a) : src_a;
    abs_b   = (sgn_div && src_b[WIDTH-1]) ? ('0 - src_b) : src_b;
    div_b   = b_zero ? WIDTH'(1) : abs_b;
    uq      = abs_a / div_b;
    ur      = abs_a % div_b;
    res_hi  = '0;
    res_lo  = '0;
    res_wr  = 1'b1;
    case (mdu_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        // MIN / -1 falls out naturally: |MIN| / 1 = MIN, remainder 0.
        res_lo = (sgn_div && (src_a[WIDTH-1] ^ src_b[WIDTH-1])) ? ('0 - uq) : uq;
        res_hi = (sgn_div && src_a[WIDTH-1]) ? ('0 - ur) : ur;
        res_wr = !b_zero;
      end
      default:  res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (launch) cnt <= is_mult ? MULT_N : DIV_N;
    else if (busy)   cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (launch) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= res_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (commit && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (mt_hi) hi <= src_a;
      if (mt_lo) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_e_mdu_multicycle.sv
// Scoreboard bench for e_mdu_multicycle: an integer model predicts HI/LO at
// issue time; results are popped and compared when busy falls.
module tb_e_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] src_a, src_b;
  logic        d_is_mdu;
  logic        busy, stall_req;
  logic [31:0] hi, lo, mdu_out;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [63:0] sb[$];

  e_mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .src_a(src_a), .src_b(src_b), .d_is_mdu(d_is_mdu),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  // Reference model: updates architectural expectation, queues mult/div results.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb_;
    sa  = int'(a);
    sb_ = int'(b);
    case (op)
      4'd1: begin p = longint'(sa) * longint'(sb_); {exp_hi, exp_lo} = p; end
      4'd2: begin {exp_hi, exp_lo} = {32'b0, a} * {32'b0, b}; end
      4'd3: if (b != 0) begin
              if (a == 32'h8000_0000 && sb_ == -1) begin exp_lo = a; exp_hi = '0; end
              else begin exp_lo = sa / sb_; exp_hi = sa % sb_; end
            end
      4'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      4'd7: exp_hi = a;
      4'd8: exp_lo = a;
      default: ;
    endcase
    if (op >= 4'd1 && op <= 4'd4) sb.push_back({exp_hi, exp_lo});
  endtask

  function automatic int lat(input logic [3:0] op);
    return (op <= 4'd2) ? 5 : 10;
  endfunction

  // Issue one op at a negedge and count busy cycles; optionally hammer mtlo while busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_mtlo, output int cyc, output bit stall_ok);
    start = 1'b1; mdu_op = op; src_a = a; src_b = b;
    #1 stall_ok = (stall_req === 1'b1);
    @(negedge clk);
    if (hold_mtlo) begin start = 1'b1; mdu_op = 4'd8; src_a = 32'hAAAA; end
    else begin start = 1'b0; mdu_op = 4'd0; end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (stall_req !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
    start = 1'b0; mdu_op = 4'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; mdu_op = '0; src_a = '0; src_b = '0; d_is_mdu = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd5;
    #1;
    nvec++; if (hi !== 32'h0)     begin nerr++; $display("FAIL reset_hi got %h want 0", hi); end
    nvec++; if (lo !== 32'h0)     begin nerr++; $display("FAIL reset_lo got %h want 0", lo); end
    nvec++; if (busy !== 1'b0)    begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (stall_req !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", stall_req); end
    nvec++; if (mdu_out !== 32'h0) begin nerr++; $display("FAIL reset_mfhi got %h want 0", mdu_out); end
    @(negedge clk);
    start = 1'b0; mdu_op = '0;
  endtask

  task automatic test_mult;
    int cyc; bit sok; logic [63:0] e;
    logic [3:0] ops [2] = '{4'd1, 4'd2};
    foreach (ops[i]) begin
      model(ops[i], 32'hFFFF_FFFE, 32'd3);
      run_op(ops[i], 32'hFFFF_FFFE, 32'd3, 1'b0, cyc, sok);
      nvec++; if (cyc !== 5) begin nerr++; $display("FAIL mult_latency op%0d got %0d want 5", ops[i], cyc); end
      nvec++; if (!sok) begin nerr++; $display("FAIL mult_stall op%0d got 0 want 1", ops[i]); end
      e = sb.pop_front();
      nvec++; if ({hi, lo} !== e) begin nerr++; $display("FAIL mult_result op%0d got %h_%h want %h", ops[i], hi, lo, e); end
    end
    nvec++; if (hi !== 32'h2 || lo !== 32'hFFFF_FFFA) begin nerr++; $display("FAIL multu_literal got %h_%h want 00000002_fffffffa", hi, lo); end
    start = 1'b1; mdu_op = 4'd5; #1;
    nvec++; if (mdu_out !== exp_hi) begin nerr++; $display("FAIL mfhi got %h want %h", mdu_out, exp_hi); end
    mdu_op = 4'd6; #1;
    nvec++; if (mdu_out !== exp_lo) begin nerr++; $display("FAIL mflo got %h want %h", mdu_out, exp_lo); end
    @(negedge clk);
    start = 1'b0; mdu_op = '0;
  endtask

  task automatic test_div;
    int cyc; bit sok; logic [63:0] e;
    logic [31:0] as [2] = '{32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bs [2] = '{32'd2, 32'hFFFF_FFFF};
    foreach (as[i]) begin
      model(4'd3, as[i], bs[i]);
      run_op(4'd3, as[i], bs[i], 1'b0, cyc, sok);
      nvec++; if (cyc !== 10) begin nerr++; $display("FAIL div_latency #%0d got %0d want 10", i, cyc); end
      e = sb.pop_front();
      nvec++; if ({hi, lo} !== e) begin nerr++; $display("FAIL div_result #%0d got %h_%h want %h", i, hi, lo, e); end
    end
  endtask

  task automatic test_divzero;
    int cyc; bit sok; logic [63:0] e;
    model(4'd7, 32'h1234, 32'h0);
    start = 1'b1; mdu_op = 4'd7; src_a = 32'h1234;
    @(negedge clk);
    start = 1'b0; mdu_op = '0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mthi_busy got %b want 0", busy); end
    nvec++; if (hi !== exp_hi) begin nerr++; $display("FAIL mthi got %h want %h", hi, exp_hi); end
    model(4'd4, 32'd5, 32'd0);
    run_op(4'd4, 32'd5, 32'd0, 1'b0, cyc, sok);
    nvec++; if (cyc !== 10) begin nerr++; $display("FAIL divz_latency got %0d want 10", cyc); end
    e = sb.pop_front();
    nvec++; if ({hi, lo} !== e) begin nerr++; $display("FAIL divz_result got %h_%h want %h", hi, lo, e); end
  endtask

  task automatic test_reset_midop;
    start = 1'b1; mdu_op = 4'd1; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; mdu_op = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0; sb.delete();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    nvec++; if ({hi, lo} !== 64'h0) begin nerr++; $display("FAIL rst_mid_hilo got %h_%h want 0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    nvec++; if (busy !== 1'b0 || {hi, lo} !== 64'h0) begin
      nerr++; $display("FAIL rst_no_commit got busy=%b %h_%h want 0 0_0", busy, hi, lo);
    end
  endtask

  task automatic test_busy_start;
    int cyc; bit sok; logic [63:0] e;
    model(4'd1, 32'd100, 32'hFFFF_FFFD);
    run_op(4'd1, 32'd100, 32'hFFFF_FFFD, 1'b1, cyc, sok);
    nvec++; if (cyc !== 5) begin nerr++; $display("FAIL busymt_latency got %0d want 5", cyc); end
    nvec++; if (!sok) begin nerr++; $display("FAIL busymt_stall got 0 want 1"); end
    e = sb.pop_front();
    nvec++; if ({hi, lo} !== e) begin nerr++; $display("FAIL busymt_result got %h_%h want %h", hi, lo, e); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit sok; logic [63:0] e;
    logic [3:0] op; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 17)) : $urandom;
      if (i % 2 == 1) b = -b;
      model(op, a, b);
      run_op(op, a, b, 1'b0, cyc, sok);
      nvec++; if (cyc !== lat(op)) begin nerr++; $display("FAIL b2b_latency #%0d op%0d got %0d want %0d", i, op, cyc, lat(op)); end
      e = sb.pop_front();
      nvec++; if ({hi, lo} !== e) begin nerr++; $display("FAIL b2b_result #%0d op%0d a=%h b=%h got %h_%h want %h", i, op, a, b, hi, lo, e); end
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_reset_midop;
    test_busy_start;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
